// File: rtl/ls_compare_ctrl.sv
// ls_compare_ctrl: lockstep control and compare stage wrapped around the boot counter.
// Sequences IDLE -> CLEAR -> WAIT_BOOT -> ACTIVE, compares main/shadow vectors while
// ACTIVE, and escalates ERR_THRESH consecutive mismatches to a sticky FATAL state.
// Optional first-mismatch syndrome capture is enabled by defining LS_MISMATCH_SYNDROME_EN.
// All outputs are registered; reset is synchronous and active-high.

module ls_compare_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned TOT_CNT_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ls_enable_req,
  input  logic                 i_ls_disable_req,
  input  logic                 i_err_clear,
  input  logic                 i_count_done,
  output logic [1:0]           o_clear_counter,
  input  logic                 i_cmp_valid,
  input  logic [DATA_W-1:0]    i_main_data,
  input  logic [DATA_W-1:0]    i_shdw_data,
  output logic                 o_ls_active,
  output logic                 o_ls_err_transient,
  output logic                 o_ls_err_fatal,
  output logic [TOT_CNT_W-1:0] o_mismatch_tot,
  output logic [DATA_W-1:0]    o_mismatch_syn
);

  // Consecutive counter is 4 bits wide: ERR_THRESH is limited to 1..15.
  localparam logic [3:0]           ThreshVal = 4'(ERR_THRESH);
  localparam logic [1:0]           CcHold    = 2'b01;
  localparam logic [1:0]           CcRun     = 2'b00;
  localparam logic [TOT_CNT_W-1:0] TotOne    = {{(TOT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOT_CNT_W-1:0] TotMax    = {TOT_CNT_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitBoot,
    StActive,
    StFatal
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [3:0]             r_consec;
  logic [3:0]             w_consec_d;
  logic [3:0]             w_consec_inc;
  logic [1:0]             r_clear_counter;
  logic [1:0]             w_clear_counter_d;
  logic                   r_ls_active;
  logic                   w_ls_active_d;
  logic                   r_err_transient;
  logic                   w_err_transient_d;
  logic                   r_err_fatal;
  logic                   w_err_fatal_d;
  logic [TOT_CNT_W-1:0]   r_mismatch_tot;
  logic [TOT_CNT_W-1:0]   w_mismatch_tot_d;

  logic                   w_cmp_fire;
  logic                   w_data_eq;
  logic                   w_mismatch;
  logic                   w_match;
  logic                   w_hit_thresh;
  logic                   w_fatal_clear;

  // A compare only counts in ACTIVE; a same-cycle disable discards it entirely.
  assign w_cmp_fire    = (r_state == StActive) && i_cmp_valid && !i_ls_disable_req;
  assign w_data_eq     = (i_main_data == i_shdw_data);
  assign w_mismatch    = w_cmp_fire && !w_data_eq;
  assign w_match       = w_cmp_fire && w_data_eq;
  assign w_consec_inc  = r_consec + 4'd1;
  assign w_hit_thresh  = w_mismatch && (w_consec_inc == ThreshVal);
  assign w_fatal_clear = (r_state == StFatal) && i_err_clear;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; disable outranks boot completion and threshold escalation.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_ls_enable_req) begin
          w_state_d = StClear;
        end
      end
      StClear: begin
        w_state_d = StWaitBoot;
      end
      StWaitBoot: begin
        if (i_ls_disable_req) begin
          w_state_d = StIdle;
        end else if (i_count_done) begin
          w_state_d = StActive;
        end
      end
      StActive: begin
        if (i_ls_disable_req) begin
          w_state_d = StIdle;
        end else if (w_hit_thresh) begin
          w_state_d = StFatal;
        end
      end
      StFatal: begin
        if (i_err_clear) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Output and counter next values, decoded from the next state so outputs stay registered.
  always_comb begin
    w_clear_counter_d = CcHold;
    w_ls_active_d     = 1'b0;
    w_err_fatal_d     = 1'b0;
    w_err_transient_d = w_mismatch;
    w_mismatch_tot_d  = r_mismatch_tot;
    w_consec_d        = r_consec;

    unique case (w_state_d)
      StWaitBoot: begin
        w_clear_counter_d = CcRun;
      end
      StActive: begin
        w_clear_counter_d = CcRun;
        w_ls_active_d     = 1'b1;
      end
      StFatal: begin
        w_err_fatal_d = 1'b1;
      end
      default: begin
        w_clear_counter_d = CcHold;
      end
    endcase

    if (w_mismatch && (r_mismatch_tot != TotMax)) begin
      w_mismatch_tot_d = r_mismatch_tot + TotOne;
    end

    // Any exit from ACTIVE (disable or escalation) restarts the consecutive run.
    if (w_state_d != StActive) begin
      w_consec_d = 4'd0;
    end else if (w_mismatch) begin
      w_consec_d = w_consec_inc;
    end else if (w_match) begin
      w_consec_d = 4'd0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clear_counter <= CcHold;
      r_ls_active     <= 1'b0;
      r_err_transient <= 1'b0;
      r_err_fatal     <= 1'b0;
      r_mismatch_tot  <= '0;
      r_consec        <= 4'd0;
    end else begin
      r_clear_counter <= w_clear_counter_d;
      r_ls_active     <= w_ls_active_d;
      r_err_transient <= w_err_transient_d;
      r_err_fatal     <= w_err_fatal_d;
      r_mismatch_tot  <= w_mismatch_tot_d;
      r_consec        <= w_consec_d;
    end
  end

  assign o_clear_counter    = r_clear_counter;
  assign o_ls_active        = r_ls_active;
  assign o_ls_err_transient = r_err_transient;
  assign o_ls_err_fatal     = r_err_fatal;
  assign o_mismatch_tot     = r_mismatch_tot;

`ifdef LS_MISMATCH_SYNDROME_EN
  logic [DATA_W-1:0] r_mismatch_syn;

  // First-mismatch syndrome; a real mismatch XOR is never zero, so zero means "not captured".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mismatch_syn <= '0;
    end else if (w_fatal_clear) begin
      r_mismatch_syn <= '0;
    end else if (w_mismatch && (r_mismatch_syn == '0)) begin
      r_mismatch_syn <= i_main_data ^ i_shdw_data;
    end
  end

  assign o_mismatch_syn = r_mismatch_syn;
`else
  logic w_unused_fatal_clear;
  assign w_unused_fatal_clear = w_fatal_clear;
  assign o_mismatch_syn       = '0;
`endif

endmodule

// File: tb/tb_ls_compare_ctrl.sv
// tb_ls_compare_ctrl: directed, table-driven bench for ls_compare_ctrl.
// Syndrome expectations follow LS_MISMATCH_SYNDROME_EN when it is defined for the build.

module tb_ls_compare_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        dis;
  logic        ec;
  logic        cd;
  logic [1:0]  cc;
  logic        v;
  logic [31:0] m;
  logic [31:0] s;
  logic        act;
  logic        trans;
  logic        fatal;
  logic [7:0]  tot;
  logic [31:0] syn;

  int checks   = 0;
  int failures = 0;

`ifdef LS_MISMATCH_SYNDROME_EN
  localparam logic [31:0] SynFirst = 32'h0000_0001;
  localparam logic [31:0] SynDis   = 32'h0000_0003;
`else
  localparam logic [31:0] SynFirst = 32'h0;
  localparam logic [31:0] SynDis   = 32'h0;
`endif

  always #5 clk = ~clk;

  ls_compare_ctrl #(
    .DATA_W    (32),
    .ERR_THRESH(3),
    .TOT_CNT_W (8)
  ) u_dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ls_enable_req   (en),
    .i_ls_disable_req  (dis),
    .i_err_clear       (ec),
    .i_count_done      (cd),
    .o_clear_counter   (cc),
    .i_cmp_valid       (v),
    .i_main_data       (m),
    .i_shdw_data       (s),
    .o_ls_active       (act),
    .o_ls_err_transient(trans),
    .o_ls_err_fatal    (fatal),
    .o_mismatch_tot    (tot),
    .o_mismatch_syn    (syn)
  );

  typedef struct packed {
    logic        en;
    logic        dis;
    logic        ec;
    logic        cd;
    logic        v;
    logic [31:0] m;
    logic [31:0] s;
    logic        e_t;
    logic        e_f;
    logic        e_a;
    logic [1:0]  e_cc;
    logic [7:0]  e_tot;
    logic [31:0] e_syn;
  } vec_t;

  vec_t tbl [0:18];

  function automatic vec_t mk(input logic ien, input logic idis, input logic iec, input logic icd,
                              input logic iv, input logic [31:0] im, input logic [31:0] is,
                              input logic et, input logic ef, input logic ea,
                              input logic [1:0] ecc, input logic [7:0] etot,
                              input logic [31:0] esyn);
    vec_t r;
    r.en = ien; r.dis = idis; r.ec = iec; r.cd = icd; r.v = iv; r.m = im; r.s = is;
    r.e_t = et; r.e_f = ef; r.e_a = ea; r.e_cc = ecc; r.e_tot = etot; r.e_syn = esyn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: enable at cycle 0, count_done during cycle 27, ACTIVE from cycle 28.
  task automatic boot(input string tag);
    en = 1'b1;
    step();
    chk({tag, "_c1_cc"}, 32'(cc), 32'h1);
    chk({tag, "_c1_act"}, 32'(act), 32'h0);
    en = 1'b0;
    step();
    chk({tag, "_c2_cc"}, 32'(cc), 32'h0);
    repeat (25) step();
    chk({tag, "_c27_act"}, 32'(act), 32'h0);
    chk({tag, "_c27_cc"}, 32'(cc), 32'h0);
    cd = 1'b1;
    step();
    chk({tag, "_c28_act"}, 32'(act), 32'h1);
    cd = 1'b0;
  endtask

  task automatic cmp(input logic [31:0] im, input logic [31:0] is);
    v = 1'b1; m = im; s = is;
    step();
    v = 1'b0;
  endtask

  initial begin
    // Transient / counter-reset / fatal-with-gaps / fatal-hold / recovery sequence.
    //          en dis ec cd v  main          shdw          t  f  a  cc     tot    syn
    tbl[0]  = mk(0, 0, 0, 0, 1, 32'h0000_00F0, 32'h0000_00F1, 1, 0, 1, 2'b00, 8'd1, SynFirst);
    tbl[1]  = mk(0, 0, 0, 0, 1, 32'h5,         32'h5,         0, 0, 1, 2'b00, 8'd1, SynFirst);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h1,         32'h2,         0, 0, 1, 2'b00, 8'd1, SynFirst);
    tbl[3]  = mk(0, 0, 0, 0, 1, 32'hAA,        32'hAA,        0, 0, 1, 2'b00, 8'd1, SynFirst);
    tbl[4]  = mk(0, 0, 0, 0, 1, 32'h1,         32'h0,         1, 0, 1, 2'b00, 8'd2, SynFirst);
    tbl[5]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 1, 2'b00, 8'd2, SynFirst);
    tbl[6]  = mk(0, 0, 0, 0, 1, 32'h3,         32'h1,         1, 0, 1, 2'b00, 8'd3, SynFirst);
    tbl[7]  = mk(0, 0, 0, 0, 1, 32'h7,         32'h7,         0, 0, 1, 2'b00, 8'd3, SynFirst);
    tbl[8]  = mk(0, 0, 0, 0, 1, 32'h8,         32'h0,         1, 0, 1, 2'b00, 8'd4, SynFirst);
    tbl[9]  = mk(0, 0, 0, 0, 1, 32'h9,         32'h9,         0, 0, 1, 2'b00, 8'd4, SynFirst);
    tbl[10] = mk(0, 0, 0, 0, 1, 32'h10,        32'h11,        1, 0, 1, 2'b00, 8'd5, SynFirst);
    tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,         32'h1,         0, 0, 1, 2'b00, 8'd5, SynFirst);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 1, 2'b00, 8'd5, SynFirst);
    tbl[13] = mk(0, 0, 0, 0, 1, 32'hC,         32'hD,         1, 0, 1, 2'b00, 8'd6, SynFirst);
    tbl[14] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 1, 2'b00, 8'd6, SynFirst);
    tbl[15] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0,         1, 1, 0, 2'b01, 8'd7, SynFirst);
    tbl[16] = mk(1, 1, 0, 1, 1, 32'h1,         32'h2,         0, 1, 0, 2'b01, 8'd7, SynFirst);
    tbl[17] = mk(0, 0, 1, 0, 0, 32'h0,         32'h0,         0, 0, 0, 2'b01, 8'd7, 32'h0);
    tbl[18] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 2'b01, 8'd7, 32'h0);

    rst = 1'b1; en = 1'b0; dis = 1'b0; ec = 1'b0; cd = 1'b0; v = 1'b0; m = '0; s = '0;
    step();
    chk("rst_cc", 32'(cc), 32'h1);
    chk("rst_act", 32'(act), 32'h0);
    chk("rst_trans", 32'(trans), 32'h0);
    chk("rst_fatal", 32'(fatal), 32'h0);
    chk("rst_tot", 32'(tot), 32'h0);
    chk("rst_syn", syn, 32'h0);
    rst = 1'b0;

    boot("boot1");
    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en; dis = tbl[i].dis; ec = tbl[i].ec; cd = tbl[i].cd;
      v = tbl[i].v; m = tbl[i].m; s = tbl[i].s;
      step();
      chk($sformatf("vec%0d_trans", i), 32'(trans), 32'(tbl[i].e_t));
      chk($sformatf("vec%0d_fatal", i), 32'(fatal), 32'(tbl[i].e_f));
      chk($sformatf("vec%0d_act", i), 32'(act), 32'(tbl[i].e_a));
      chk($sformatf("vec%0d_cc", i), 32'(cc), 32'(tbl[i].e_cc));
      chk($sformatf("vec%0d_tot", i), 32'(tot), 32'(tbl[i].e_tot));
      chk($sformatf("vec%0d_syn", i), syn, tbl[i].e_syn);
    end
    en = 1'b0; dis = 1'b0; ec = 1'b0; cd = 1'b0; v = 1'b0;

    // Disable beats count_done in WAIT_BOOT.
    en = 1'b1; step();
    en = 1'b0; step();
    chk("wb_cc", 32'(cc), 32'h0);
    cd = 1'b1; dis = 1'b1; step();
    chk("wbdis_cc", 32'(cc), 32'h1);
    chk("wbdis_act", 32'(act), 32'h0);
    cd = 1'b0; dis = 1'b0; step();
    chk("wbdis_idle_act", 32'(act), 32'h0);
    chk("wbdis_idle_cc", 32'(cc), 32'h1);

    // Disable discards a same-cycle mismatch and clears the consecutive run.
    boot("boot2");
    cmp(32'h1, 32'h2);
    chk("pre_dis_tot1", 32'(tot), 32'd8);
    cmp(32'h1, 32'h2);
    chk("pre_dis_tot2", 32'(tot), 32'd9);
    dis = 1'b1;
    cmp(32'h4, 32'h5);
    dis = 1'b0;
    chk("dis_act", 32'(act), 32'h0);
    chk("dis_trans", 32'(trans), 32'h0);
    chk("dis_tot", 32'(tot), 32'd9);
    chk("dis_cc", 32'(cc), 32'h1);
    chk("dis_syn", syn, SynDis);
    boot("boot3");
    cmp(32'h4, 32'h5);
    chk("reen_trans", 32'(trans), 32'h1);
    chk("reen_fatal", 32'(fatal), 32'h0);
    chk("reen_tot", 32'(tot), 32'd10);

    // Saturation: 300 mismatches, never three in a row.
    cmp(32'h6, 32'h6);
    for (int k = 0; k < 300; k++) begin
      cmp(32'h0, 32'(k + 1));
      if (k == 243) chk("sat_tot_254", 32'(tot), 32'd254);
      if (k % 2 == 1) cmp(32'h3, 32'h3);
    end
    chk("sat_tot", 32'(tot), 32'd255);
    chk("sat_fatal", 32'(fatal), 32'h0);
    chk("sat_act", 32'(act), 32'h1);

    // Fatal at saturation, enable ignored, then err_clear recovery.
    cmp(32'h1, 32'h0);
    cmp(32'h1, 32'h0);
    chk("f2_fatal", 32'(fatal), 32'h0);
    cmp(32'h1, 32'h0);
    chk("f3_fatal", 32'(fatal), 32'h1);
    chk("f3_act", 32'(act), 32'h0);
    chk("f3_cc", 32'(cc), 32'h1);
    chk("f3_tot", 32'(tot), 32'd255);
    en = 1'b1; step(); en = 1'b0;
    chk("fen_fatal", 32'(fatal), 32'h1);
    ec = 1'b1; step(); ec = 1'b0;
    chk("clr_fatal", 32'(fatal), 32'h0);
    chk("clr_tot", 32'(tot), 32'd255);
    chk("clr_cc", 32'(cc), 32'h1);
    chk("clr_syn", syn, 32'h0);

    // Reset wins over an in-flight mismatch in ACTIVE.
    boot("boot4");
    rst = 1'b1;
    cmp(32'h1, 32'h2);
    rst = 1'b0;
    chk("rst2_trans", 32'(trans), 32'h0);
    chk("rst2_tot", 32'(tot), 32'h0);
    chk("rst2_act", 32'(act), 32'h0);
    chk("rst2_cc", 32'(cc), 32'h1);
    chk("rst2_syn", syn, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
